// File: rtl/tile_l15_req_arbiter_if.sv
// tile_l15_req_arbiter_if: request/response bundle between tile requesters, the arbiter and the L1.5 channel
interface tile_l15_req_arbiter_if #(
  parameter int NumPorts  = 6,
  parameter int DataWidth = 128
);
  localparam int PidW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  logic [NumPorts-1:0]           req_valid;
  logic [NumPorts-1:0]           req_ready;
  logic [NumPorts*DataWidth-1:0] req_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DataWidth-1:0]          out_data;
  logic [PidW-1:0]               out_portid;
  logic [NumPorts-1:0]           resp_done;
  logic                          quiesce_req;
  logic                          quiesce_ack;
  logic                          wake;
  logic                          err;
  modport master (
    output req_valid, req_data, out_ready, resp_done, quiesce_req,
    input  req_ready, out_valid, out_data, out_portid, quiesce_ack, wake, err
  );
  modport slave (
    input  req_valid, req_data, out_ready, resp_done, quiesce_req,
    output req_ready, out_valid, out_data, out_portid, quiesce_ack, wake, err
  );
endinterface

// File: rtl/tile_l15_req_arbiter.sv
// tile_l15_req_arbiter: N-port arbiter feeding the single L1.5 request channel with outstanding limits and quiesce
module tile_l15_req_arbiter #(
  parameter int NumPorts       = 6,
  parameter int DataWidth      = 128,
  parameter int ArbMode        = 0,
  parameter int MaxOutstanding = 4,
  parameter int StarveTh       = 16,
  parameter int WakeUpCycles   = 32768
) (
  input logic clk_i,
  input logic rst_ni,
  tile_l15_req_arbiter_if.slave bus
);
  localparam int PidW  = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam int StvW  = $clog2(StarveTh + 1);
  localparam int WakeW = WakeUpCycles > 1 ? $clog2(WakeUpCycles) : 1;
  typedef enum logic [1:0] {WAKE, RUN, DRAIN, IDLE} state_t;
  state_t              state;
  logic [WakeW-1:0]    wake_cnt;
  logic [CntW-1:0]     cnt [NumPorts];
  logic [CntW-1:0]     cnt_nxt [NumPorts];
  logic [StvW-1:0]     starve [NumPorts];
  logic [NumPorts-1:0] elig;
  logic [NumPorts-1:0] promo;
  logic [PidW-1:0]     rr;
  logic [PidW-1:0]     gnt;
  logic                slot_free;
  logic                grant;
  logic                err_set;
  logic                busy;
  logic                drained;
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign grant     = state == RUN && slot_free && |elig;
  assign bus.req_ready = grant ? NumPorts'(1) << gnt : '0;
  assign drained   = !busy && !(bus.out_valid && !bus.out_ready);
  // a port may compete while it has room for another outstanding request; long losers get promoted
  always_comb begin
    elig  = '0;
    promo = '0;
    for (int p = 0; p < NumPorts; p++) begin
      elig[p]  = bus.req_valid[p] && cnt[p] < CntW'(MaxOutstanding);
      promo[p] = elig[p] && starve[p] >= StvW'(StarveTh);
    end
  end
  // winner: lowest promoted port, otherwise lowest index or first eligible at/after the rr pointer
  always_comb begin
    gnt = '0;
    for (int k = NumPorts - 1; k >= 0; k--)
      if (elig[ArbMode == 1 ? (int'(rr) + k) % NumPorts : k])
        gnt = PidW'(ArbMode == 1 ? (int'(rr) + k) % NumPorts : k);
    for (int p = NumPorts - 1; p >= 0; p--)
      if (promo[p]) gnt = PidW'(p);
  end
  // next outstanding counts; a completion with nothing outstanding flags an error
  always_comb begin
    err_set = 1'b0;
    busy    = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      cnt_nxt[p] = bus.req_ready[p] && !bus.resp_done[p] ? cnt[p] + 1'b1 :
                   !bus.req_ready[p] && bus.resp_done[p] && cnt[p] != '0 ? cnt[p] - 1'b1 : cnt[p];
      err_set    = err_set | (!bus.req_ready[p] && bus.resp_done[p] && cnt[p] == '0);
      busy       = busy | (cnt_nxt[p] != '0);
    end
  end
  // control FSM plus the registered output slot, rr pointer and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= WAKE;
      wake_cnt        <= '0;
      bus.wake        <= 1'b0;
      bus.quiesce_ack <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_portid  <= '0;
      bus.err         <= 1'b0;
      rr              <= '0;
    end else begin
      case (state)
        WAKE:
          if (wake_cnt == WakeW'(WakeUpCycles - 1)) begin
            state    <= RUN;
            bus.wake <= 1'b1;
          end else wake_cnt <= wake_cnt + 1'b1;
        RUN:
          if (bus.quiesce_req) state <= DRAIN;
        DRAIN:
          if (!bus.quiesce_req) state <= RUN;
          else if (drained) begin
            state           <= IDLE;
            bus.quiesce_ack <= 1'b1;
          end
        IDLE:
          if (!bus.quiesce_req) begin
            state           <= RUN;
            bus.quiesce_ack <= 1'b0;
          end
      endcase
      if (grant) begin
        bus.out_valid  <= 1'b1;
        bus.out_data   <= bus.req_data[int'(gnt) * DataWidth +: DataWidth];
        bus.out_portid <= gnt;
        rr             <= gnt == PidW'(NumPorts - 1) ? '0 : gnt + 1'b1;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
      if (err_set) bus.err <= 1'b1;
    end
  end
  // per-port outstanding counters and starvation ages
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        cnt[p]    <= '0;
        starve[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        cnt[p]    <= cnt_nxt[p];
        starve[p] <= !elig[p] || bus.req_ready[p] ? '0 :
                     state == RUN && starve[p] != StvW'(StarveTh) ? starve[p] + 1'b1 : starve[p];
      end
    end
  end
endmodule

// File: tb/tb_tile_l15_req_arbiter.sv
// tb_tile_l15_req_arbiter: fixed-priority and round-robin arbiters checked against a behavioural model
module tb_tile_l15_req_arbiter;
  localparam int NP = 6, DW = 16, MO = 2, ST = 8, WK = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] req_valid;
  logic [NP*DW-1:0] req_data;
  logic out_ready, quiesce;
  logic [NP-1:0] rd [2];
  logic [28:0] dv [2];
  int checks = 0, fails = 0;
  int m_ph[2], m_wk[2], m_rr[2], m_g[2], m_op[2];
  int m_cnt[2][NP], m_stv[2][NP];
  bit m_ov[2], m_err[2], m_wake[2], m_ack[2];
  logic [DW-1:0] m_od[2];
  tile_l15_req_arbiter_if #(.NumPorts(NP), .DataWidth(DW)) b0 ();
  tile_l15_req_arbiter_if #(.NumPorts(NP), .DataWidth(DW)) b1 ();
  tile_l15_req_arbiter #(.NumPorts(NP), .DataWidth(DW), .ArbMode(0), .MaxOutstanding(MO), .StarveTh(ST), .WakeUpCycles(WK))
    u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0.slave));
  tile_l15_req_arbiter #(.NumPorts(NP), .DataWidth(DW), .ArbMode(1), .MaxOutstanding(MO), .StarveTh(ST), .WakeUpCycles(WK))
    u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
  assign b0.req_valid = req_valid;
  assign b1.req_valid = req_valid;
  assign b0.req_data = req_data;
  assign b1.req_data = req_data;
  assign b0.out_ready = out_ready;
  assign b1.out_ready = out_ready;
  assign b0.quiesce_req = quiesce;
  assign b1.quiesce_req = quiesce;
  assign b0.resp_done = rd[0];
  assign b1.resp_done = rd[1];
  assign dv[0] = {b0.req_ready, b0.out_valid, b0.out_data, b0.out_portid, b0.quiesce_ack, b0.wake, b0.err};
  assign dv[1] = {b1.req_ready, b1.out_valid, b1.out_data, b1.out_portid, b1.quiesce_ack, b1.wake, b1.err};
  always #5 clk = ~clk;

  function automatic logic [NP*DW-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic void mreset(int m);
    m_ph[m] = 0; m_wk[m] = 0; m_rr[m] = 0; m_g[m] = -1; m_op[m] = 0;
    m_ov[m] = 0; m_err[m] = 0; m_wake[m] = 0; m_ack[m] = 0; m_od[m] = '0;
    for (int p = 0; p < NP; p++) begin m_cnt[m][p] = 0; m_stv[m][p] = 0; end
  endfunction

  function automatic bit elig(int m, int p);
    return req_valid[p] && m_cnt[m][p] < MO;
  endfunction

  // phases: 0 waking, 1 running, 2 draining, 3 idle
  function automatic void pick(int m);
    int q;
    m_g[m] = -1;
    if (m_ph[m] == 1 && (!m_ov[m] || out_ready)) begin
      for (int p = 0; p < NP; p++) if (m_g[m] < 0 && elig(m, p) && m_stv[m][p] >= ST) m_g[m] = p;
      for (int k = 0; k < NP; k++) begin
        q = (k + (m == 1 ? m_rr[m] : 0)) % NP;
        if (m_g[m] < 0 && elig(m, q)) m_g[m] = q;
      end
    end
  endfunction

  function automatic void step(int m);
    int g;
    bit busy;
    g = m_g[m];
    busy = 0;
    for (int p = 0; p < NP; p++) begin
      if (!elig(m, p) || g == p) m_stv[m][p] = 0;
      else if (m_ph[m] == 1 && m_stv[m][p] < ST) m_stv[m][p]++;
      if (g == p && !rd[m][p]) m_cnt[m][p]++;
      else if (g != p && rd[m][p]) begin
        if (m_cnt[m][p] > 0) m_cnt[m][p]--; else m_err[m] = 1;
      end
      if (m_cnt[m][p] != 0) busy = 1;
    end
    if (g >= 0) begin
      m_ov[m] = 1; m_od[m] = req_data[g*DW +: DW]; m_op[m] = g; m_rr[m] = (g + 1) % NP;
    end else if (out_ready) m_ov[m] = 0;
    case (m_ph[m])
      0: if (m_wk[m] == WK - 1) begin m_ph[m] = 1; m_wake[m] = 1; end else m_wk[m]++;
      1: if (quiesce) m_ph[m] = 2;
      2: if (!quiesce) m_ph[m] = 1; else if (!m_ov[m] && !busy) begin m_ph[m] = 3; m_ack[m] = 1; end
      default: if (!quiesce) begin m_ph[m] = 1; m_ack[m] = 0; end
    endcase
  endfunction

  function automatic logic [28:0] mvec(int m);
    logic [NP-1:0] r;
    r = m_g[m] >= 0 ? NP'(1) << m_g[m] : '0;
    return {r, m_ov[m], m_od[m], 3'(m_op[m]), m_ack[m], m_wake[m], m_err[m]};
  endfunction

  function automatic logic [NP-1:0] owed(int m);
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = m_cnt[m][p] > 0;
    return r;
  endfunction

  task automatic pre();
    #1;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) mreset(m);
      pick(m);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int m = 0; m < 2; m++) if (!rst_n) mreset(m); else step(m);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = '1; req_data = rnd(); out_ready = 1; quiesce = 0; rd[0] = '0; rd[1] = '0;
    mreset(0); mreset(1);
    repeat (3) @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dv[m] !== '0) begin fails++; $display("FAIL reset dut%0d got=%h exp=0", m, dv[m]); end
    end
  endtask

  task automatic test_wake();
    int first;
    first = -1;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      req_data = rnd();
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL wake dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      if (first < 0 && b0.req_ready !== '0) first = c;
      adv();
    end
    checks++;
    if (first != 8) begin fails++; $display("FAIL wake_first got=%0d exp=8", first); end
    checks++;
    if (b0.wake !== 1'b1 || b1.wake !== 1'b1) begin fails++; $display("FAIL wake_flag got=%b%b exp=11", b0.wake, b1.wake); end
  endtask

  task automatic test_round_robin();
    int tally [NP];
    for (int p = 0; p < NP; p++) tally[p] = 0;
    req_valid = '1; out_ready = 1;
    for (int c = 0; c < 40; c++) begin
      req_data = rnd(); rd[0] = owed(0); rd[1] = owed(1);
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL rr dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      if (c >= 28) for (int p = 0; p < NP; p++) if (b1.req_ready[p]) tally[p]++;
      adv();
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (tally[p] != 2) begin fails++; $display("FAIL rr_share port%0d got=%0d exp=2", p, tally[p]); end
    end
  endtask

  task automatic test_outstanding();
    int n0, n1;
    req_valid = '0; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      rd[0] = owed(0); rd[1] = owed(1);
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL out_drain dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      adv();
    end
    rd[0] = '0; rd[1] = '0; req_valid = 6'b000100; n0 = 0; n1 = 0;
    for (int c = 0; c < 6; c++) begin
      req_data = rnd();
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL out_cap dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      n0 += int'(b0.req_ready[2]); n1 += int'(b1.req_ready[2]);
      adv();
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin fails++; $display("FAIL outstanding_cap got=%0d/%0d exp=2", n0, n1); end
    rd[0] = 6'b000100; rd[1] = 6'b000100; n0 = 0; n1 = 0;
    for (int c = 0; c < 5; c++) begin
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL out_ret dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      n0 += int'(b0.req_ready[2]); n1 += int'(b1.req_ready[2]);
      adv();
      rd[0] = '0; rd[1] = '0;
    end
    checks++;
    if (n0 != 1 || n1 != 1) begin fails++; $display("FAIL outstanding_refill got=%0d/%0d exp=1", n0, n1); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    d = DW'($urandom);
    rd[0] = '0; rd[1] = '0; req_valid = 6'b010000; req_data = rnd(); req_data[4*DW +: DW] = d; out_ready = 0;
    pre();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dv[m] !== mvec(m)) begin fails++; $display("FAIL bp_grant dut%0d got=%h exp=%h", m, dv[m], mvec(m)); end
    end
    adv();
    for (int c = 0; c < 5; c++) begin
      req_data = rnd();
      pre();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_data !== d || b0.out_portid !== 3'd4 || b0.req_ready !== '0 ||
          b1.out_valid !== 1'b1 || b1.out_data !== d || b1.out_portid !== 3'd4 || b1.req_ready !== '0) begin
        fails++;
        $display("FAIL bp_hold cyc%0d got=%b/%h/%0d/%b %b/%h/%0d/%b exp=1/%h/4/0", c, b0.out_valid, b0.out_data,
                 b0.out_portid, b0.req_ready, b1.out_valid, b1.out_data, b1.out_portid, b1.req_ready, d);
      end
      adv();
    end
    out_ready = 1;
    pre();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dv[m] !== mvec(m)) begin fails++; $display("FAIL bp_release dut%0d got=%h exp=%h", m, dv[m], mvec(m)); end
    end
    adv();
  endtask

  task automatic test_quiesce();
    req_valid = '0; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      rd[0] = c < 3 ? owed(0) : '0; rd[1] = c < 3 ? owed(1) : '0;
      req_valid = c >= 3 && c < 5 ? 6'b000010 : '0;
      quiesce = c >= 5;
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL q_setup dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      if (c >= 6) begin
        checks++;
        if (b0.quiesce_ack !== 1'b0 || b1.quiesce_ack !== 1'b0 || b0.req_ready !== '0 || b1.req_ready !== '0) begin
          fails++; $display("FAIL q_hold cyc%0d got=%b%b/%h%h exp=00/00", c, b0.quiesce_ack, b1.quiesce_ack, b0.req_ready, b1.req_ready);
        end
      end
      adv();
    end
    for (int c = 0; c < 4; c++) begin
      rd[0] = c[0] ? '0 : 6'b000010; rd[1] = rd[0];
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL q_resp dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      if (c[0]) begin
        checks++;
        if (b0.quiesce_ack !== (c == 3) || b1.quiesce_ack !== (c == 3) || b0.err !== 1'b0) begin
          fails++; $display("FAIL q_ack cyc%0d got=%b%b err=%b exp=%0d%0d err=0", c, b0.quiesce_ack, b1.quiesce_ack, b0.err, c == 3, c == 3);
        end
      end
      adv();
    end
    rd[0] = 6'b000001; rd[1] = 6'b000001;
    pre();
    adv();
    rd[0] = '0; rd[1] = '0;
    for (int c = 0; c < 3; c++) begin
      pre();
      checks++;
      if (b0.err !== 1'b1 || b1.err !== 1'b1) begin fails++; $display("FAIL err_sticky cyc%0d got=%b%b exp=11", c, b0.err, b1.err); end
      adv();
    end
    for (int c = 0; c < 4; c++) begin
      quiesce = c >= 2; req_valid = c == 1 ? 6'b000010 : '0; out_ready = c < 2;
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL q_redrain dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      if (c < 3) adv();
    end
    checks++;
    if (b0.out_valid !== 1'b1 || b1.out_valid !== 1'b1) begin fails++; $display("FAIL q_pending got=%b%b exp=11", b0.out_valid, b1.out_valid); end
    rst_n = 0;
    pre();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dv[m] !== '0) begin fails++; $display("FAIL reset_async dut%0d got=%h exp=0", m, dv[m]); end
    end
    adv();
    quiesce = 0; out_ready = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n = !(c >= 350 && c < 352);
      req_valid = NP'($urandom); req_data = rnd(); out_ready = ($urandom % 4) != 0;
      quiesce = (c % 100) >= 80;
      rd[0] = NP'($urandom & $urandom & $urandom); rd[1] = NP'($urandom & $urandom & $urandom);
      pre();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dv[m] !== mvec(m)) begin fails++; $display("FAIL random dut%0d cyc%0d got=%h exp=%h", m, c, dv[m], mvec(m)); end
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_round_robin();
    test_outstanding();
    test_backpressure();
    test_quiesce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
